// File: rtl/alu_seq_muldiv_pkg.sv
// Shared opcode map and FSM encoding for the registered ALU and its
// iterative multiply/divide engine.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_INV  = 4'hA;
  localparam logic [3:0] OP_NAND = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC;
  localparam logic [3:0] OP_XOR  = 4'hD;
  localparam logic [3:0] OP_XNOR = 4'hE;
  localparam logic [3:0] OP_BUF  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // MUL and DIV go through the multi-cycle engine; everything else is one cycle.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Operation/result handshake bundle between issue logic, the ALU and writeback.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 8
);
  logic                 en;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           command;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   y;
  logic                 carry;
  logic                 zero;
  logic                 div_err;

  // Issue/writeback side.
  modport master (
    output en, in_valid, a, b, command, out_ready,
    input  in_ready, out_valid, y, carry, zero, div_err
  );

  // ALU side.
  modport slave (
    input  en, in_valid, a, b, command, out_ready,
    output in_ready, out_valid, y, carry, zero, div_err
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one
// {hi,lo} register pair. One bit per cycle for WIDTH cycles after start;
// done is high during the final step and result carries that step's outcome.
module alu_iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             mode_div, busy;
  logic [CW-1:0]    cnt;

  // One iteration step: multiply adds the multiplicand into hi and shifts the
  // pair right; divide shifts the pair left and restores when the trial
  // subtraction borrows. With b==0 the subtraction never borrows, so the
  // quotient fills with ones and a shifts through into the remainder.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hi_nxt    = hi;
    lo_nxt    = lo;
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (mode_div) begin
      if (!div_diff[WIDTH]) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Operand load on start, then WIDTH iteration steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      mode_div <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
    end else if (start) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      busy     <= 1'b1;
      mode_div <= is_div;
      cnt      <= '0;
      hi       <= '0;
      lo       <= is_div ? a : b;
      opnd     <= is_div ? b : a;
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) busy <= 1'b0;
    end
  end

  assign done   = busy && (cnt == CW'(WIDTH - 1));
  assign result = {hi_nxt, lo_nxt};

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered 16-command ALU with valid/ready on both sides. Single-cycle ops
// complete on the accept edge; MUL/DIV hand off to alu_iter_muldiv.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_seq_muldiv_if.slave  bus
);

  state_t               state;
  logic [2*WIDTH-1:0]   y_q;
  logic                 carry_q, zero_q, div_err_q, out_valid_q, err_pend;
  logic                 accept, iter_start, iter_done;
  logic [2*WIDTH-1:0]   iter_res;
  logic [2*WIDTH-1:0]   op_y;
  logic                 op_carry;
  logic [WIDTH:0]       ext;

  // Held low during reset so nothing is taken while the block is cleared.
  assign bus.in_ready = rst_n & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;
  assign iter_start   = accept & is_iter_op(bus.command);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .is_div (bus.command == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .done   (iter_done),
    .result (iter_res)
  );

  // Single-cycle result and carry/borrow straight from the live inputs.
  always_comb begin
    op_y     = '0;
    op_carry = 1'b0;
    ext      = '0;
    case (bus.command)
      OP_ADD:  ext = {1'b0, bus.a} + {1'b0, bus.b};
      OP_INC:  ext = {1'b0, bus.a} + (WIDTH+1)'(1);
      OP_SUB:  ext = {1'b0, bus.a} - {1'b0, bus.b};
      OP_DEC:  ext = {1'b0, bus.a} - (WIDTH+1)'(1);
      OP_SHR:  op_y[WIDTH-1:0] = bus.a >> 1;
      OP_SHL:  op_y[WIDTH:0]   = {bus.a, 1'b0};
      OP_AND:  op_y[WIDTH-1:0] = bus.a & bus.b;
      OP_OR:   op_y[WIDTH-1:0] = bus.a | bus.b;
      OP_INV:  op_y[WIDTH-1:0] = ~bus.a;
      OP_NAND: op_y[WIDTH-1:0] = ~(bus.a & bus.b);
      OP_NOR:  op_y[WIDTH-1:0] = ~(bus.a | bus.b);
      OP_XOR:  op_y[WIDTH-1:0] = bus.a ^ bus.b;
      OP_XNOR: op_y[WIDTH-1:0] = ~(bus.a ^ bus.b);
      OP_BUF:  op_y[WIDTH-1:0] = bus.a;
      default: op_y = '0;
    endcase
    if (bus.command inside {OP_ADD, OP_INC, OP_SUB, OP_DEC}) begin
      op_y[WIDTH:0] = ext;
      op_carry      = ext[WIDTH];
    end
  end

  // Control FSM plus result/flag register; a result holds until out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      div_err_q   <= 1'b0;
      err_pend    <= 1'b0;
    end else if (accept) begin
      if (is_iter_op(bus.command)) begin
        state       <= BUSY;
        out_valid_q <= 1'b0;
        err_pend    <= (bus.command == OP_DIV) && (bus.b == '0);
      end else begin
        state       <= DONE;
        out_valid_q <= 1'b1;
        y_q         <= op_y;
        carry_q     <= op_carry;
        zero_q      <= (op_y == '0);
        div_err_q   <= 1'b0;
      end
    end else begin
      case (state)
        BUSY: if (iter_done) begin
          state       <= DONE;
          out_valid_q <= 1'b1;
          y_q         <= iter_res;
          carry_q     <= 1'b0;
          zero_q      <= (iter_res == '0);
          div_err_q   <= err_pend;
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = bus.en ? y_q : '0;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.div_err   = div_err_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv at WIDTH=8: reset, arithmetic corners,
// MUL/DIV latency, backpressure, reset abort, output enable, and a corner-value
// sweep of all 16 commands against an integer reference model.
module tb_alu_seq_muldiv;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  alu_seq_muldiv_if #(.WIDTH(8)) bus ();

  alu_seq_muldiv #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Integer reference for y, carry and div_err.
  function automatic void ref_model(input logic [3:0] cmd, input logic [7:0] av, input logic [7:0] bv,
                                    output logic [15:0] ey, output logic ec, output logic ee);
    int ia = int'(av);
    int ib = int'(bv);
    int r;
    ec = 1'b0;
    ee = 1'b0;
    ey = 16'h0000;
    case (cmd)
      OP_ADD:  begin r = ia + ib; ec = (r > 255); ey = 16'(r); end
      OP_INC:  begin r = ia + 1;  ec = (r > 255); ey = 16'(r); end
      OP_SUB:  begin ec = (ia < ib); ey = 16'((ia - ib + 512) % 512); end
      OP_DEC:  begin ec = (ia == 0); ey = 16'((ia + 511) % 512); end
      OP_MUL:  ey = 16'(ia * ib);
      OP_DIV:  if (ib == 0) begin ee = 1'b1; ey = 16'(ia * 256 + 255); end
               else ey = 16'((ia % ib) * 256 + ia / ib);
      OP_SHR:  ey = 16'(ia / 2);
      OP_SHL:  ey = 16'(ia * 2);
      OP_AND:  ey = {8'h00, av & bv};
      OP_OR:   ey = {8'h00, av | bv};
      OP_INV:  ey = 16'(255 - ia);
      OP_NAND: ey = {8'h00, ~(av & bv)};
      OP_NOR:  ey = {8'h00, ~(av | bv)};
      OP_XOR:  ey = {8'h00, av ^ bv};
      OP_XNOR: ey = {8'h00, ~(av ^ bv)};
      default: ey = {8'h00, av};
    endcase
  endfunction

  // Issue one op, wait for its result, hold it `hold` cycles, then consume it.
  // Starts and ends 1 time unit after a rising edge.
  task automatic run_op(input logic [3:0] cmd, input logic [7:0] av, input logic [7:0] bv,
                        input int hold, output logic [15:0] ry, output logic rc,
                        output logic rz, output logic re, output int lat);
    int guard = 0;
    logic [15:0] first_y;
    bus.command  = cmd;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", 16'(bus.in_ready), 16'h0001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
    bus.command  = ~cmd;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      check("busy_in_ready", 16'(bus.in_ready), 16'h0000);
      @(posedge clk); #1;
      lat++;
    end
    check("result_wait", 16'(bus.out_valid), 16'h0001);
    first_y = bus.y;
    repeat (hold) begin @(posedge clk); #1; end
    ry = bus.y;
    rc = bus.carry;
    rz = bus.zero;
    re = bus.div_err;
    if (hold > 0) check("hold_stable", ry, first_y);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ry, ey;
    logic        rc, rz, re, ec, ee;
    int          lat;
    logic [7:0]  vals [8] = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h55, 8'h80, 8'hFE, 8'hFF};

    bus.en = 1'b1; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.command = OP_ADD; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(bus.out_valid), 16'h0000);
    check("rst_in_ready",  16'(bus.in_ready),  16'h0000);
    check("rst_y",         bus.y,              16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arithmetic corners.
    run_op(OP_ADD, 8'd20, 8'd10, 0, ry, rc, rz, re, lat);
    check("add_y", ry, 16'h001E); check("add_c", 16'(rc), 16'h0000); check("add_lat", 16'(lat), 16'd1);
    run_op(OP_ADD, 8'd255, 8'd1, 1, ry, rc, rz, re, lat);
    check("add_ovf_y", ry, 16'h0100); check("add_ovf_c", 16'(rc), 16'h0001); check("add_ovf_z", 16'(rz), 16'h0000);
    run_op(OP_SUB, 8'd5, 8'd7, 0, ry, rc, rz, re, lat);
    check("sub_y", ry, 16'h01FE); check("sub_c", 16'(rc), 16'h0001);
    run_op(OP_DEC, 8'd0, 8'd0, 0, ry, rc, rz, re, lat);
    check("dec_y", ry, 16'h01FF); check("dec_c", 16'(rc), 16'h0001);

    // Multi-cycle ops.
    run_op(OP_MUL, 8'd200, 8'd200, 0, ry, rc, rz, re, lat);
    check("mul_y", ry, 16'h9C40); check("mul_lat", 16'(lat), 16'd9); check("mul_c", 16'(rc), 16'h0000);
    run_op(OP_DIV, 8'd100, 8'd7, 0, ry, rc, rz, re, lat);
    check("div_y", ry, 16'h020E); check("div_err", 16'(re), 16'h0000); check("div_lat", 16'(lat), 16'd9);
    run_op(OP_DIV, 8'd20, 8'd0, 2, ry, rc, rz, re, lat);
    check("div0_y", ry, 16'h14FF); check("div0_err", 16'(re), 16'h0001); check("div0_lat", 16'(lat), 16'd9);

    // Backpressure: result held for 5 cycles with a new op waiting.
    bus.command = OP_ADD; bus.a = 8'd3; bus.b = 8'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.command = OP_XOR; bus.a = 8'hF0; bus.b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    16'(bus.out_valid), 16'h0001);
      check("bp_y",        bus.y,              16'h0007);
      check("bp_in_ready", 16'(bus.in_ready),  16'h0000);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_ready_rise", 16'(bus.in_ready), 16'h0001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("bp_next_valid", 16'(bus.out_valid), 16'h0001);
    check("bp_next_y",     bus.y,              16'h00FF);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_drained", 16'(bus.out_valid), 16'h0000);

    // Reset in the 4th BUSY cycle of a DIV discards it.
    bus.command = OP_DIV; bus.a = 8'd200; bus.b = 8'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_valid",    16'(bus.out_valid), 16'h0000);
    check("abort_in_ready", 16'(bus.in_ready),  16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("abort_no_result", 16'(bus.out_valid), 16'h0000);

    // Output enable masks y only.
    bus.en = 1'b0;
    run_op(OP_ADD, 8'd25, 8'd17, 0, ry, rc, rz, re, lat);
    check("en0_y", ry, 16'h0000); check("en0_z", 16'(rz), 16'h0000); check("en0_lat", 16'(lat), 16'd1);
    run_op(OP_ADD, 8'd0, 8'd0, 0, ry, rc, rz, re, lat);
    check("en0_zero_y", ry, 16'h0000); check("en0_zero_z", 16'(rz), 16'h0001);
    bus.en = 1'b1;
    run_op(OP_ADD, 8'd25, 8'd17, 0, ry, rc, rz, re, lat);
    check("en1_y", ry, 16'h002A); check("en1_z", 16'(rz), 16'h0000);

    // Corner-value sweep over every command with random consumer stalls.
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          ref_model(4'(c), vals[i], vals[j], ey, ec, ee);
          run_op(4'(c), vals[i], vals[j], int'($urandom_range(0, 2)), ry, rc, rz, re, lat);
          check($sformatf("sweep_y c%0h a%02h b%02h", c, vals[i], vals[j]), ry, ey);
          check($sformatf("sweep_c c%0h a%02h b%02h", c, vals[i], vals[j]), 16'(rc), 16'(ec));
          check($sformatf("sweep_e c%0h a%02h b%02h", c, vals[i], vals[j]), 16'(re), 16'(ee));
          check($sformatf("sweep_z c%0h a%02h b%02h", c, vals[i], vals[j]), 16'(rz), 16'(ey == 16'h0000));
          check($sformatf("sweep_lat c%0h", c), 16'(lat), is_iter_op(4'(c)) ? 16'd9 : 16'd1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
